// File: rtl/pc_pkg.sv
// pc_pkg: shared next-PC select encoding and default vectors for the PC sequencer
package pc_pkg;
  localparam int W_D = 16;
  localparam logic [15:0] RESET_VEC_D = 16'h0000;
  localparam logic [15:0] TRAP_VEC_D = 16'h0004;
  typedef enum logic [2:0] {SEL_SEQ, SEL_BR, SEL_JMP, SEL_CALL, SEL_RET, SEL_TRAP, SEL_HOLD} sel_t;
endpackage

// File: rtl/pc_seq_unit_if.sv
// pc_seq_unit_if: control selects in (stall/trap/ret/call/jump/branch, jtarget, boff); PC, PCplus, RAS status out
interface pc_seq_unit_if #(parameter int W = pc_pkg::W_D, parameter int OFF_W = 8);
  logic stall, trap, ret, call, jump, branch;
  logic [W-1:0] jtarget;
  logic [OFF_W-1:0] boff;
  logic [W-1:0] PC, PCplus;
  logic ras_empty, ras_full, ras_err;
  modport master(output stall, trap, ret, call, jump, branch, jtarget, boff,
                 input PC, PCplus, ras_empty, ras_full, ras_err);
  modport slave(input stall, trap, ret, call, jump, branch, jtarget, boff,
                output PC, PCplus, ras_empty, ras_full, ras_err);
endinterface

// File: rtl/ras_stack.sv
// ras_stack: circular return-address LIFO; push/pop/din in, top/empty/full/err out; full push overwrites oldest
module ras_stack #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         nClear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         err
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW:0] count;
  assign top = mem[ptr];
  assign empty = count == '0;
  assign full = count == (PW+1)'(DEPTH);
  assign err = (pop && empty) || (push && full);
  always_ff @(posedge clk) begin
    if (!nClear) begin
      ptr <= '0;
      count <= '0;
    end else if (pop) begin
      ptr <= empty ? ptr : ptr - 1'b1;
      count <= empty ? count : count - 1'b1;
    end else if (push) begin
      ptr <= ptr + 1'b1;
      count <= full ? count : count + 1'b1;
    end
  end
  // when full, the slot after top is the oldest entry, so wrapping overwrites it
  always_ff @(posedge clk)
    if (nClear && push && !pop) mem[ptr + 1'b1] <= din;
endmodule

// File: rtl/pc_seq_unit.sv
// pc_seq_unit: fetch-stage PC sequencer; clk/nClear plus slave bus (selects in, PC/PCplus/RAS status out)
module pc_seq_unit
  import pc_pkg::*;
#(
  parameter int W = W_D,
  parameter int STEP = 1,
  parameter int OFF_W = 8,
  parameter logic [W-1:0] RESET_VEC = W'(RESET_VEC_D),
  parameter logic [W-1:0] TRAP_VEC = W'(TRAP_VEC_D),
  parameter int RAS_DEPTH = 4
) (
  input logic clk,
  input logic nClear,
  pc_seq_unit_if.slave bus
);
  if (OFF_W > W) begin : g_bad_off
    $error("OFF_W must not exceed W");
  end
  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("RAS_DEPTH must be a power of 2, at least 2");
  end
  sel_t sel;
  logic [W-1:0] pc, pc_plus, pc_next, ras_top;
  logic ras_empty, ras_full, stk_err, err_q;
  always_comb
    sel = bus.stall ? SEL_HOLD : bus.trap ? SEL_TRAP : bus.ret ? SEL_RET :
          bus.call ? SEL_CALL : bus.jump ? SEL_JMP : bus.branch ? SEL_BR : SEL_SEQ;
  assign pc_plus = pc + W'(STEP);
  always_comb begin
    pc_next = pc_plus;
    case (sel)
      SEL_HOLD: pc_next = pc;
      SEL_TRAP: pc_next = TRAP_VEC;
      SEL_RET:  pc_next = ras_empty ? RESET_VEC : ras_top;
      SEL_CALL, SEL_JMP: pc_next = bus.jtarget;
      SEL_BR:   pc_next = pc_plus + W'($signed(bus.boff));
      default:  pc_next = pc_plus;
    endcase
  end
  ras_stack #(.W(W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk),
    .nClear(nClear),
    .push(sel == SEL_CALL),
    .pop(sel == SEL_RET),
    .din(pc_plus),
    .top(ras_top),
    .empty(ras_empty),
    .full(ras_full),
    .err(stk_err)
  );
  always_ff @(posedge clk) begin
    if (!nClear) begin
      pc <= RESET_VEC;
      err_q <= 1'b0;
    end else begin
      pc <= pc_next;
      // a ret that shadows a simultaneous call is flagged as a conflict
      err_q <= stk_err || (sel == SEL_RET && bus.call);
    end
  end
  assign bus.PC = pc;
  assign bus.PCplus = pc_plus;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full = ras_full;
  assign bus.ras_err = err_q;
endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: scoreboard bench for pc_seq_unit against a queue-based behavioural model
module tb_pc_seq_unit;
  typedef struct packed {
    logic n, s, t, r, c, j, b;
    logic [15:0] jt;
    logic [7:0] bo;
  } stim_t;
  logic clk = 1'b0;
  logic nClear = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [15:0] m_pc = 16'h0;
  logic [15:0] m_ras[$];
  logic [18:0] exp_q[$];
  pc_seq_unit_if bus();
  pc_seq_unit dut(.clk(clk), .nClear(nClear), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic stim_t mk(input logic [6:0] f, input logic [15:0] jt = 16'h0, input logic [7:0] bo = 8'h0);
    return {f, jt, bo};
  endfunction
  task automatic step(input stim_t v);
    logic err;
    nClear = v.n;
    bus.stall = v.s; bus.trap = v.t; bus.ret = v.r; bus.call = v.c;
    bus.jump = v.j; bus.branch = v.b; bus.jtarget = v.jt; bus.boff = v.bo;
    err = 1'b0;
    if (!v.n) begin
      m_pc = 16'h0000;
      m_ras.delete();
    end else if (v.s) begin
    end else if (v.t) m_pc = 16'h0004;
    else if (v.r) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin
        m_pc = 16'h0000;
        err = 1'b1;
      end
      if (v.c) err = 1'b1;
    end else if (v.c) begin
      if (m_ras.size() == 4) begin
        void'(m_ras.pop_front());
        err = 1'b1;
      end
      m_ras.push_back(m_pc + 16'd1);
      m_pc = v.jt;
    end else if (v.j) m_pc = v.jt;
    else if (v.b) m_pc = m_pc + 16'd1 + {{8{v.bo[7]}}, v.bo};
    else m_pc = m_pc + 16'd1;
    exp_q.push_back({m_pc, m_ras.size() == 0, m_ras.size() == 4, err});
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    stim_t v[$];
    logic [18:0] e;
    v.push_back(mk(7'b0000000));
    v.push_back(mk(7'b0000000));
    v.push_back(mk(7'b1000000));
    v.push_back(mk(7'b1000000));
    foreach (v[i]) begin
      step(v[i]);
      e = exp_q.pop_front();
      checks++;
      if ({bus.PC, bus.ras_empty, bus.ras_full, bus.ras_err} !== e || bus.PCplus !== e[18:3] + 16'd1) begin
        failures++;
        $display("FAIL reset[%0d] got PC=%h e/f/err=%b%b%b PCplus=%h exp %h", i, bus.PC, bus.ras_empty, bus.ras_full, bus.ras_err, bus.PCplus, e);
      end
      if (i == 1) begin
        checks++;
        if (bus.PC !== 16'h0000 || bus.ras_empty !== 1'b1 || bus.ras_err !== 1'b0) begin
          failures++;
          $display("FAIL reset_state got PC=%h empty=%b err=%b exp 0000 1 0", bus.PC, bus.ras_empty, bus.ras_err);
        end
      end
    end
    checks++;
    if (bus.PC !== 16'h0002) begin
      failures++;
      $display("FAIL reset_seq got PC=%h exp 0002", bus.PC);
    end
  endtask
  task automatic test_branch_wrap();
    stim_t v[$];
    logic [18:0] e;
    v.push_back(mk(7'b1000010, 16'h0010));
    v.push_back(mk(7'b1000001, 16'h0, 8'hF0));
    v.push_back(mk(7'b1000001, 16'h0, 8'h7F));
    v.push_back(mk(7'b1000010, 16'hFFFF));
    v.push_back(mk(7'b1000000));
    v.push_back(mk(7'b1000010, 16'hFFF0));
    v.push_back(mk(7'b1000001, 16'h0, 8'h20));
    foreach (v[i]) begin
      step(v[i]);
      e = exp_q.pop_front();
      checks++;
      if ({bus.PC, bus.ras_empty, bus.ras_full, bus.ras_err} !== e || bus.PCplus !== e[18:3] + 16'd1) begin
        failures++;
        $display("FAIL branch[%0d] got PC=%h e/f/err=%b%b%b PCplus=%h exp %h", i, bus.PC, bus.ras_empty, bus.ras_full, bus.ras_err, bus.PCplus, e);
      end
      if (i == 1 || i == 4) begin
        checks++;
        if (bus.PC !== (i == 1 ? 16'h0001 : 16'h0000)) begin
          failures++;
          $display("FAIL branch_const[%0d] got PC=%h", i, bus.PC);
        end
      end
    end
  endtask
  task automatic test_call_ret();
    stim_t v[$];
    logic [18:0] e;
    v.push_back(mk(7'b1000010, 16'h0020));
    v.push_back(mk(7'b1000100, 16'h0100));
    v.push_back(mk(7'b1000000));
    v.push_back(mk(7'b1001000));
    foreach (v[i]) begin
      step(v[i]);
      e = exp_q.pop_front();
      checks++;
      if ({bus.PC, bus.ras_empty, bus.ras_full, bus.ras_err} !== e || bus.PCplus !== e[18:3] + 16'd1) begin
        failures++;
        $display("FAIL call_ret[%0d] got PC=%h e/f/err=%b%b%b exp %h", i, bus.PC, bus.ras_empty, bus.ras_full, bus.ras_err, e);
      end
    end
    checks++;
    if (bus.PC !== 16'h0021 || bus.ras_empty !== 1'b1) begin
      failures++;
      $display("FAIL call_ret_const got PC=%h empty=%b exp 0021 1", bus.PC, bus.ras_empty);
    end
  endtask
  task automatic test_ras_overflow();
    stim_t v[$];
    logic [18:0] e;
    v.push_back(mk(7'b0000000));
    for (int k = 0; k < 5; k++) v.push_back(mk(7'b1000100, 16'h0100 + 16'(k * 16)));
    for (int k = 0; k < 5; k++) v.push_back(mk(7'b1001000));
    foreach (v[i]) begin
      step(v[i]);
      e = exp_q.pop_front();
      checks++;
      if ({bus.PC, bus.ras_empty, bus.ras_full, bus.ras_err} !== e) begin
        failures++;
        $display("FAIL ras_ovf[%0d] got PC=%h e/f/err=%b%b%b exp %h", i, bus.PC, bus.ras_empty, bus.ras_full, bus.ras_err, e);
      end
    end
    checks++;
    if (bus.PC !== 16'h0000 || bus.ras_err !== 1'b1) begin
      failures++;
      $display("FAIL ras_underflow got PC=%h err=%b exp 0000 1", bus.PC, bus.ras_err);
    end
  endtask
  task automatic test_priority();
    stim_t v[$];
    logic [18:0] e;
    v.push_back(mk(7'b1000010, 16'h0040));
    v.push_back(mk(7'b1000100, 16'h0200));
    v.push_back(mk(7'b1110111, 16'h0300, 8'h05));
    v.push_back(mk(7'b1011100, 16'h0300));
    v.push_back(mk(7'b1000100, 16'h0500));
    v.push_back(mk(7'b1001100, 16'h0600));
    v.push_back(mk(7'b1000011, 16'h0700, 8'h03));
    v.push_back(mk(7'b1001000));
    foreach (v[i]) begin
      step(v[i]);
      e = exp_q.pop_front();
      checks++;
      if ({bus.PC, bus.ras_empty, bus.ras_full, bus.ras_err} !== e) begin
        failures++;
        $display("FAIL priority[%0d] got PC=%h e/f/err=%b%b%b exp %h", i, bus.PC, bus.ras_empty, bus.ras_full, bus.ras_err, e);
      end
    end
  endtask
  task automatic test_reset_mid();
    stim_t v[$];
    logic [18:0] e;
    for (int k = 0; k < 3; k++) v.push_back(mk(7'b1000100, 16'h0800 + 16'(k)));
    v.push_back(mk(7'b0100000));
    v.push_back(mk(7'b1001000));
    foreach (v[i]) begin
      step(v[i]);
      e = exp_q.pop_front();
      checks++;
      if ({bus.PC, bus.ras_empty, bus.ras_full, bus.ras_err} !== e) begin
        failures++;
        $display("FAIL reset_mid[%0d] got PC=%h e/f/err=%b%b%b exp %h", i, bus.PC, bus.ras_empty, bus.ras_full, bus.ras_err, e);
      end
      if (i == 3) begin
        checks++;
        if (bus.PC !== 16'h0000 || bus.ras_empty !== 1'b1 || bus.ras_err !== 1'b0) begin
          failures++;
          $display("FAIL reset_mid_const got PC=%h empty=%b err=%b exp 0000 1 0", bus.PC, bus.ras_empty, bus.ras_err);
        end
      end
    end
  endtask
  task automatic test_back_to_back();
    stim_t v;
    logic [18:0] e;
    for (int i = 0; i < 400; i++) begin
      v.n = $urandom_range(0, 49) != 0;
      v.s = $urandom_range(0, 9) == 0;
      v.t = $urandom_range(0, 14) == 0;
      v.r = $urandom_range(0, 4) == 0;
      v.c = $urandom_range(0, 3) == 0;
      v.j = $urandom_range(0, 5) == 0;
      v.b = $urandom_range(0, 3) == 0;
      v.jt = 16'($urandom);
      v.bo = 8'($urandom);
      step(v);
      e = exp_q.pop_front();
      checks++;
      if ({bus.PC, bus.ras_empty, bus.ras_full, bus.ras_err} !== e || bus.PCplus !== e[18:3] + 16'd1) begin
        failures++;
        $display("FAIL random[%0d] got PC=%h e/f/err=%b%b%b PCplus=%h exp %h", i, bus.PC, bus.ras_empty, bus.ras_full, bus.ras_err, bus.PCplus, e);
      end
    end
  endtask
  initial begin
    {bus.stall, bus.trap, bus.ret, bus.call, bus.jump, bus.branch} = '0;
    bus.jtarget = '0;
    bus.boff = '0;
    test_reset();
    test_branch_wrap();
    test_call_ret();
    test_ras_overflow();
    test_priority();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
